// File: rtl/gmcu_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : gmcu_inst_encoder
// Purpose  : Encoder side of the GMCU bit-I/O instruction stream. Takes one
//            bit-I/O request per handshake and emits one (short form) or two
//            (long form) 16-bit instruction words over a valid/ready stream.
//            All stream outputs are registered; back-to-back requests run at
//            one word per cycle.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            reqValid/reqReady           - request handshake
//            reqOp/reqAddr/reqBit/reqDst - request fields
//            instValid/instReady         - instruction word handshake
//            instWord/instLast           - word and end-of-instruction flag
//            instParity                  - even-parity bit of instWord
//            encErr                      - pulse when a reserved op is dropped
//            instCount                   - completed-instruction counter
// Options  : GMCU_ENC_PARITY_EN - when defined, instParity carries the XOR
//            of instWord; otherwise it is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module gmcu_inst_encoder #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqOp,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [2:0]        reqBit,
  input  logic [3:0]        reqDst,
  output logic              instValid,
  input  logic              instReady,
  output logic [15:0]       instWord,
  output logic              instLast,
  output logic              instParity,
  output logic              encErr,
  output logic [CNT_W-1:0]  instCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W0   = 2'd1,
    S_W1   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [15:0]       word_q, word_d;
  logic              last_q, last_d;
  logic              ext_q, ext_d;
  logic [15:0]       word1_q, word1_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              addr_ext;
  logic [3:0]        opc;
  logic [15:0]       word0;
  logic [15:0]       word1;
  logic              accept;
  logic              last_taken;

  // Long form is needed whenever any address bit above the low nibble is set.
  if (ADDR_W > 4) begin : g_ext_wide
    assign addr_ext = |reqAddr[ADDR_W-1:4];
  end else begin : g_ext_narrow
    assign addr_ext = 1'b0;
  end

  always_comb begin
    opc = 4'h0;
    case (reqOp)
      2'd0:    opc = 4'hA;
      2'd1:    opc = 4'hB;
      2'd2:    opc = 4'h5;
      default: opc = 4'h0;
    endcase
  end

  assign word0 = {opc, addr_ext, reqBit, reqDst, reqAddr[3:0]};
  assign word1 = 16'(reqAddr);

  // A new request may enter when nothing is presented, or when the final
  // word of the current instruction leaves this cycle (no bubble).
  assign reqReady   = !valid_q || (instReady && last_q);
  assign accept     = reqValid && reqReady;
  assign last_taken = valid_q && instReady && last_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    word_d  = word_q;
    last_d  = last_q;
    ext_d   = ext_q;
    word1_d = word1_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    if (last_taken) begin
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else if (valid_q && instReady && (state_q == S_W0) && ext_q) begin
      state_d = S_W1;
      word_d  = word1_q;
      last_d  = 1'b1;
    end

    // A same-cycle accept overrides the drain-to-IDLE above.
    if (accept) begin
      if (reqOp == 2'd3) begin
        err_d = 1'b1;
      end else begin
        state_d = S_W0;
        valid_d = 1'b1;
        word_d  = word0;
        last_d  = !addr_ext;
        ext_d   = addr_ext;
        word1_d = addr_ext ? word1 : 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      word_q  <= 16'h0000;
      last_q  <= 1'b0;
      ext_q   <= 1'b0;
      word1_q <= 16'h0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      last_q  <= last_d;
      ext_q   <= ext_d;
      word1_q <= word1_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef GMCU_ENC_PARITY_EN
  // Registered from the next word so parity always matches instWord.
  logic parity_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^word_d;
    end
  end
  assign instParity = parity_q;
`else
  assign instParity = 1'b0;
`endif

  assign instValid = valid_q;
  assign instWord  = word_q;
  assign instLast  = last_q;
  assign encErr    = err_q;
  assign instCount = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gmcu_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gmcu_inst_encoder
// Purpose  : Self-checking bench for gmcu_inst_encoder: directed scenarios
//            followed by randomized traffic against a word-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gmcu_inst_encoder;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              reqValid;
  logic              reqReady;
  logic [1:0]        reqOp;
  logic [ADDR_W-1:0] reqAddr;
  logic [2:0]        reqBit;
  logic [3:0]        reqDst;
  logic              instValid;
  logic              instReady;
  logic [15:0]       instWord;
  logic              instLast;
  logic              instParity;
  logic              encErr;
  logic [CNT_W-1:0]  instCount;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] word;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  gmcu_inst_encoder #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqOp      (reqOp),
    .reqAddr    (reqAddr),
    .reqBit     (reqBit),
    .reqDst     (reqDst),
    .instValid  (instValid),
    .instReady  (instReady),
    .instWord   (instWord),
    .instLast   (instLast),
    .instParity (instParity),
    .encErr     (encErr),
    .instCount  (instCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // Expected parity of a word under the current build.
  function automatic logic exp_par(input logic [15:0] w);
`ifdef GMCU_ENC_PARITY_EN
    return ^w;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: appends the words a request should produce.
  task automatic model_push(input int op, input int addr, input int bitn, input int dst);
    int   opc;
    int   lng;
    exp_t e;
    opc = (op == 0) ? 10 : (op == 1) ? 11 : 5;
    lng = (addr >= 16) ? 1 : 0;
    e.word = 16'(opc * 4096 + lng * 2048 + bitn * 256 + dst * 16 + (addr % 16));
    e.last = (lng == 0);
    exp_q.push_back(e);
    if (lng == 1) begin
      e.word = 16'(addr);
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] op, input int addr, input int bitn, input int dst);
    reqValid = v;
    reqOp    = op;
    reqAddr  = ADDR_W'(addr);
    reqBit   = 3'(bitn);
    reqDst   = 4'(dst);
  endtask

  task automatic do_reset();
    set_req(1'b0, 2'd0, 0, 0, 0);
    instReady = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    set_req(1'b0, 2'd0, 0, 0, 0);
    instReady = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", instValid); end
    n_cmp++; if (instWord !== 16'h0000) begin n_err++; $display("FAIL reset_word: got %h required 0000", instWord); end
    n_cmp++; if (instLast !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b required 0", instLast); end
    n_cmp++; if (instParity !== 1'b0) begin n_err++; $display("FAIL reset_parity: got %b required 0", instParity); end
    n_cmp++; if (encErr !== 1'b0) begin n_err++; $display("FAIL reset_encerr: got %b required 0", encErr); end
    n_cmp++; if (instCount !== '0) begin n_err++; $display("FAIL reset_count: got %0d required 0", instCount); end
    n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL reset_reqready: got %b required 1", reqReady); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_short();
    do_reset();
    set_req(1'b1, 2'd0, 'h009, 5, 3);
    tick();
    set_req(1'b0, 2'd0, 0, 0, 0);
    n_cmp++; if (instValid !== 1'b1) begin n_err++; $display("FAIL short_valid: got %b required 1", instValid); end
    n_cmp++; if (instWord !== 16'hA539) begin n_err++; $display("FAIL short_word: got %h required a539", instWord); end
    n_cmp++; if (instLast !== 1'b1) begin n_err++; $display("FAIL short_last: got %b required 1", instLast); end
    n_cmp++; if (instParity !== exp_par(16'hA539)) begin n_err++; $display("FAIL short_parity: got %b required %b", instParity, exp_par(16'hA539)); end
    tick();
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL short_idle: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd1) begin n_err++; $display("FAIL short_count: got %0d required 1", instCount); end
  endtask

  task automatic test_long();
    do_reset();
    set_req(1'b1, 2'd1, 'h123, 2, 1);
    tick();
    set_req(1'b0, 2'd0, 0, 0, 0);
    n_cmp++; if (instWord !== 16'hBA13) begin n_err++; $display("FAIL long_w0: got %h required ba13", instWord); end
    n_cmp++; if (instLast !== 1'b0) begin n_err++; $display("FAIL long_w0_last: got %b required 0", instLast); end
    n_cmp++; if (reqReady !== 1'b0) begin n_err++; $display("FAIL long_reqready: got %b required 0", reqReady); end
    n_cmp++; if (instParity !== exp_par(16'hBA13)) begin n_err++; $display("FAIL long_w0_parity: got %b required %b", instParity, exp_par(16'hBA13)); end
    tick();
    n_cmp++; if (instWord !== 16'h0123) begin n_err++; $display("FAIL long_w1: got %h required 0123", instWord); end
    n_cmp++; if (instLast !== 1'b1) begin n_err++; $display("FAIL long_w1_last: got %b required 1", instLast); end
    n_cmp++; if (instParity !== exp_par(16'h0123)) begin n_err++; $display("FAIL long_w1_parity: got %b required %b", instParity, exp_par(16'h0123)); end
    tick();
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL long_idle: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd1) begin n_err++; $display("FAIL long_count: got %0d required 1", instCount); end
  endtask

  task automatic test_backpressure();
    do_reset();
    instReady = 1'b0;
    set_req(1'b1, 2'd1, 'h123, 2, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      // Keep offering a different request; it must not be taken.
      set_req(1'b1, 2'd0, 'h0FF, 7, 15);
      #1;
      n_cmp++; if (instWord !== 16'hBA13) begin n_err++; $display("FAIL bp_word[%0d]: got %h required ba13", i, instWord); end
      n_cmp++; if (instLast !== 1'b0) begin n_err++; $display("FAIL bp_last[%0d]: got %b required 0", i, instLast); end
      n_cmp++; if (reqReady !== 1'b0) begin n_err++; $display("FAIL bp_reqready[%0d]: got %b required 0", i, reqReady); end
      tick();
    end
    set_req(1'b0, 2'd0, 0, 0, 0);
    instReady = 1'b1;
    tick();
    n_cmp++; if (instWord !== 16'h0123) begin n_err++; $display("FAIL bp_w1: got %h required 0123", instWord); end
    n_cmp++; if (instLast !== 1'b1) begin n_err++; $display("FAIL bp_w1_last: got %b required 1", instLast); end
    tick();
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd1) begin n_err++; $display("FAIL bp_count: got %0d required 1", instCount); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h5012;
    exp_w[1] = 16'h5734;
    exp_w[2] = 16'h536F;
    do_reset();
    set_req(1'b1, 2'd2, 'h002, 0, 1);
    tick();
    set_req(1'b1, 2'd2, 'h004, 7, 3);
    #1;
    n_cmp++; if (reqReady !== 1'b1) begin n_err++; $display("FAIL b2b_reqready: got %b required 1", reqReady); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (instValid !== 1'b1 || instWord !== exp_w[i]) begin n_err++; $display("FAIL b2b_word[%0d]: got v=%b %h required v=1 %h", i, instValid, instWord, exp_w[i]); end
      tick();
      if (i == 0) set_req(1'b1, 2'd2, 'h00F, 3, 6);
      else        set_req(1'b0, 2'd0, 0, 0, 0);
    end
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd3) begin n_err++; $display("FAIL b2b_count: got %0d required 3", instCount); end
  endtask

  task automatic test_reserved();
    do_reset();
    set_req(1'b1, 2'd3, 'h123, 1, 1);
    tick();
    set_req(1'b0, 2'd0, 0, 0, 0);
    n_cmp++; if (encErr !== 1'b1) begin n_err++; $display("FAIL rsv_encerr: got %b required 1", encErr); end
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL rsv_valid: got %b required 0", instValid); end
    tick();
    n_cmp++; if (encErr !== 1'b0) begin n_err++; $display("FAIL rsv_encerr_pulse: got %b required 0", encErr); end
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL rsv_valid2: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd0) begin n_err++; $display("FAIL rsv_count: got %0d required 0", instCount); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1'b1, 2'd2, 'h001, 1, 1);
    tick();
    set_req(1'b1, 2'd1, 'h123, 2, 1);
    tick();
    set_req(1'b0, 2'd0, 0, 0, 0);
    tick();
    n_cmp++; if (instWord !== 16'h0123 || instCount !== 16'd1) begin n_err++; $display("FAIL rmid_pre: got %h cnt %0d required 0123 cnt 1", instWord, instCount); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b required 0", instValid); end
    n_cmp++; if (instCount !== 16'd0) begin n_err++; $display("FAIL rmid_count: got %0d required 0", instCount); end
    #3;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (instValid !== 1'b0) begin n_err++; $display("FAIL rmid_nopartial: got %b required 0", instValid); end
    set_req(1'b1, 2'd0, 'h009, 5, 3);
    tick();
    set_req(1'b0, 2'd0, 0, 0, 0);
    n_cmp++; if (instWord !== 16'hA539 || instLast !== 1'b1) begin n_err++; $display("FAIL rmid_restart: got %h last %b required a539 last 1", instWord, instLast); end
    tick();
    n_cmp++; if (instCount !== 16'd1) begin n_err++; $display("FAIL rmid_count2: got %0d required 1", instCount); end
  endtask

  task automatic test_random();
    int   exp_cnt;
    logic err_next;
    logic exp_ready;
    exp_t e;
    do_reset();
    exp_q.delete();
    exp_cnt  = 0;
    err_next = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_req(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4095)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      instReady = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (exp_q.size() == 0) || (instReady && exp_q[0].last);
      n_cmp++; if (reqReady !== exp_ready) begin n_err++; $display("FAIL rnd_reqready@%0d: got %b required %b", cyc, reqReady, exp_ready); end
      if (instValid && instReady) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rnd_unexpected@%0d: got word %h required none", cyc, instWord);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (instWord !== e.word || instLast !== e.last) begin n_err++; $display("FAIL rnd_word@%0d: got %h/%b required %h/%b", cyc, instWord, instLast, e.word, e.last); end
          n_cmp++; if (instParity !== exp_par(e.word)) begin n_err++; $display("FAIL rnd_parity@%0d: got %b required %b", cyc, instParity, exp_par(e.word)); end
          if (e.last) exp_cnt++;
        end
      end
      if (reqValid && reqReady) begin
        if (reqOp == 2'd3) err_next = 1'b1;
        else model_push(int'(reqOp), int'(reqAddr), int'(reqBit), int'(reqDst));
      end
      tick();
      n_cmp++; if (encErr !== err_next) begin n_err++; $display("FAIL rnd_encerr@%0d: got %b required %b", cyc, encErr, err_next); end
      err_next = 1'b0;
      n_cmp++; if (instCount !== CNT_W'(exp_cnt)) begin n_err++; $display("FAIL rnd_count@%0d: got %0d required %0d", cyc, instCount, exp_cnt); end
      n_cmp++; if (instValid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b required %b", cyc, instValid, exp_q.size() != 0); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    instReady = 1'b0;
    set_req(1'b0, 2'd0, 0, 0, 0);
    test_reset();
    test_short();
    test_long();
    test_backpressure();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gmcu_inst_encoder.md
Name: gmcu_inst_encoder

Overview:
- Encoder side of the GMCU bit-I/O instruction stream. The decoder classifies these words into the instruction class.
- Accepts one high-level bit-I/O request per handshake and emits one or two 16-bit instruction words over a valid/ready stream.
- Sits between the GMCU control sequencer (request side) and the instruction queue feeding the decoder.
- Fully registered outputs; back-to-back requests sustain one word per cycle.

Parameters:
- ADDR_W, 12, IO address width. Legal range 4..16.
- CNT_W, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- reqValid  input  1  request valid
- reqReady  output  1  request accepted when reqValid && reqReady
- reqOp  input  2  0=LDBIT, 1=STBIT, 2=BOOL, 3=reserved
- reqAddr  input  ADDR_W  IO address
- reqBit  input  3  bit index
- reqDst  input  4  destination register
- instValid  output  1  instWord valid
- instReady  input  1  downstream accepts when instValid && instReady
- instWord  output  16  encoded instruction word
- instLast  output  1  final word of the current instruction
- instParity  output  1  even-parity bit of instWord (see Optional Feature)
- encErr  output  1  one-cycle pulse when a reserved op is dropped
- instCount  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset values (async, rst_n=0): instValid=0, instWord=0, instLast=0, instParity=0, encErr=0, instCount=0, internal ext/word1 registers cleared, state=IDLE.
- Opcode map: LDBIT=4'hA, STBIT=4'hB, BOOL=4'h5.
- Short form (reqAddr < 16): single word {opc, 1'b0, reqBit, reqDst, reqAddr[3:0]}.
- Long form (reqAddr >= 16):
  - word0 = {opc, 1'b1, reqBit, reqDst, reqAddr[3:0]}
  - word1 = reqAddr zero-extended to 16 bits
- States:
  - IDLE: instValid=0.
  - W0: word0 presented; instLast = !ext.
  - W1: word1 presented; instLast=1.
- reqReady = !instValid || (instValid && instReady && instLast). Combinational from state and instReady.
- Accept with reqOp in 0..2: next cycle, state=W0 holding word0. word1 is stored if ext=1. Latency from accept to instValid is 1 cycle.
- Accept with reqOp=3: no word emitted and state unchanged from the IDLE-or-drain path. encErr=1 for exactly the next cycle. instCount unchanged.
- In W0 with ext=1 and instReady=1: go to W1 next cycle.
- Last word taken (instValid && instReady && instLast):
  - instCount increments by 1, wrapping at 2^CNT_W.
  - If a request is accepted in the same cycle, load its word0 (no bubble).
  - Otherwise go to IDLE.
- While instValid=1 && instReady=0: instWord, instLast and instParity hold stable. Request fields are ignored.
- Reset asserted mid-instruction (W0 or W1) aborts the instruction. No partial word is emitted after reset release.

Optional Feature:
- Macro: GMCU_ENC_PARITY_EN.
- Defined: instParity is registered alongside instWord and equals the XOR of all 16 bits of instWord, so word plus parity has even parity.
- Not defined: instParity is tied to 0 and no parity logic is synthesised. The port remains present.

Test Plan:
- Short form: reset, then LDBIT addr=0x009 bit=5 dst=3 with instReady=1. Required: instWord=0xA539, instLast=1 one cycle after accept; instCount=1; with GMCU_ENC_PARITY_EN, instParity=0.
- Long form: STBIT addr=0x123 bit=2 dst=1. Required: 0xBA13 (instLast=0) then 0x0123 (instLast=1) on consecutive cycles; reqReady=0 during the 0xBA13 cycle.
- Backpressure: hold instReady=0 for 5 cycles while a long word0 is presented. Required: 0xBA13 stable all 5 cycles, reqReady=0; release gives 0x0123 then completion.
- Back-to-back: three short BOOL requests with reqValid and instReady held high. Required: three words on three consecutive cycles with no bubble; instCount=3.
- Reserved op: reqOp=3. Required: encErr=1 for exactly one cycle, instValid stays 0, instCount unchanged.
- Reset mid-op: rst_n low asynchronously during the long-form W1 cycle. Required: instValid=0 immediately; instCount=0; next request starts cleanly at word0.
